// File: rtl/pin_entry_ctrl.sv
// pin_entry_ctrl: card/keypad front end for the PIN-compare stage.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   card_valid, card_ok     card-reader strobe and result
//   key_valid, key_data     keypad strobe and nibble
//   welcome_in              PIN-compare result
//   HasAccess, Input_Pin    drive the PIN-compare stage
//   grant, locked           door-release and lockout levels
//   fail_evt, timeout_evt   one-cycle event pulses
//   tries                   consecutive wrong-PIN count
module pin_entry_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CHECK_WAIT     = 2,
    parameter int MAX_TRIES      = 3,
    parameter int GRANT_CYCLES   = 50,
    parameter int LOCK_CYCLES    = 500
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           card_valid,
    input  logic                           card_ok,
    input  logic                           key_valid,
    input  logic [3:0]                     key_data,
    input  logic                           welcome_in,
    output logic                           HasAccess,
    output logic [3:0]                     Input_Pin,
    output logic                           grant,
    output logic                           locked,
    output logic                           fail_evt,
    output logic                           timeout_evt,
    output logic [$clog2(MAX_TRIES+1)-1:0] tries
);

    localparam int TRW  = $clog2(MAX_TRIES + 1);
    localparam int TM0  = (TIMEOUT_CYCLES > GRANT_CYCLES)
                        ? TIMEOUT_CYCLES : GRANT_CYCLES;
    localparam int TM1  = (LOCK_CYCLES > CHECK_WAIT)
                        ? LOCK_CYCLES : CHECK_WAIT;
    localparam int TMAX = (TM0 > TM1) ? TM0 : TM1;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_PIN,
        S_CHECK,
        S_GRANTED,
        S_LOCKED
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_timer;
    logic [TRW-1:0]  w_tries_inc;

    // Saturating increment; tries can never exceed MAX_TRIES.
    assign w_tries_inc = (tries == TRW'(MAX_TRIES))
                       ? tries : tries + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            HasAccess   <= 1'b0;
            Input_Pin   <= 4'h0;
            grant       <= 1'b0;
            locked      <= 1'b0;
            fail_evt    <= 1'b0;
            timeout_evt <= 1'b0;
            tries       <= '0;
        end else begin
            fail_evt    <= 1'b0;
            timeout_evt <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    if (card_valid && card_ok) begin
                        r_state   <= S_WAIT_PIN;
                        HasAccess <= 1'b1;
                    end
                end
                S_WAIT_PIN: begin
                    // A key on the expiry cycle takes priority.
                    if (key_valid) begin
                        Input_Pin <= key_data;
                        r_state   <= S_CHECK;
                        r_timer   <= '0;
                    end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        r_state     <= S_IDLE;
                        r_timer     <= '0;
                        HasAccess   <= 1'b0;
                        Input_Pin   <= 4'h0;
                        timeout_evt <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (r_timer == TW'(CHECK_WAIT - 1)) begin
                        r_timer <= '0;
                        if (welcome_in) begin
                            r_state   <= S_GRANTED;
                            grant     <= 1'b1;
                            tries     <= '0;
                            HasAccess <= 1'b0;
                        end else begin
                            fail_evt  <= 1'b1;
                            tries     <= w_tries_inc;
                            Input_Pin <= 4'h0;
                            if (w_tries_inc == TRW'(MAX_TRIES)) begin
                                r_state   <= S_LOCKED;
                                locked    <= 1'b1;
                                HasAccess <= 1'b0;
                            end else begin
                                r_state <= S_WAIT_PIN;
                            end
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_GRANTED: begin
                    if (r_timer == TW'(GRANT_CYCLES - 1)) begin
                        r_state   <= S_IDLE;
                        r_timer   <= '0;
                        grant     <= 1'b0;
                        // IDLE always presents a cleared PIN.
                        Input_Pin <= 4'h0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (r_timer == TW'(LOCK_CYCLES - 1)) begin
                        r_state <= S_IDLE;
                        r_timer <= '0;
                        locked  <= 1'b0;
                        tries   <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/pin_entry_ctrl.md
Name: pin_entry_ctrl

Overview:
- Front-end controller that feeds the PIN-compare stage.
- Accepts a card-reader result and one keypad nibble, then drives that stage's access-enable and 4-bit PIN inputs.
- Consumes the stage's welcome result and manages retry counting, timeout, door-grant hold and lockout.
- Sits between the card/keypad interfaces and the PIN comparator.

Parameters:
- TIMEOUT_CYCLES, 1000: cycles allowed in WAIT_PIN before abandoning the session.
- CHECK_WAIT, 2: cycles spent in CHECK before sampling welcome_in; must be ≥1.
- MAX_TRIES, 3: consecutive wrong PINs that trigger lockout; must be ≥1.
- GRANT_CYCLES, 50: cycles grant is held high.
- LOCK_CYCLES, 500: cycles spent in LOCKED.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- card_valid  in  1  single-cycle strobe: a card read has completed.
- card_ok  in  1  card recognised; qualified by card_valid.
- key_valid  in  1  single-cycle strobe: keypad nibble available.
- key_data  in  4  keypad nibble; qualified by key_valid.
- welcome_in  in  1  welcome result from the PIN-compare stage.
- HasAccess  out  1  access enable to the compare stage.
- Input_Pin  out  4  registered PIN to the compare stage.
- grant  out  1  door-release level.
- locked  out  1  lockout indicator level.
- fail_evt  out  1  one-cycle pulse on each wrong PIN.
- timeout_evt  out  1  one-cycle pulse when a session times out.
- tries  out  $clog2(MAX_TRIES+1)  consecutive-failure count.

Behaviour:
- One clock, one FSM: IDLE, WAIT_PIN, CHECK, GRANTED, LOCKED. All outputs are registered.
- A single shared down/up timer is cleared on every state entry.
- Reset (rst_n=0 at a clk edge): state IDLE; HasAccess=0, Input_Pin=0, grant=0, locked=0, fail_evt=0, timeout_evt=0, tries=0, timer=0. Reset overrides any state mid-operation, including GRANTED and LOCKED.
- IDLE:
  - card_valid&&card_ok → WAIT_PIN, HasAccess=1 from the next cycle.
  - card_valid&&!card_ok → stay IDLE, no output change.
  - key_valid is ignored.
- WAIT_PIN:
  - key_valid → Input_Pin<=key_data, go to CHECK.
  - Else, if timer reaches TIMEOUT_CYCLES-1 → go to IDLE, HasAccess=0, Input_Pin=0, timeout_evt=1 for one cycle. tries is kept.
  - key_valid in the same cycle as timer expiry: the key wins and no timeout is raised.
  - card_valid is ignored.
- CHECK:
  - HasAccess=1 and Input_Pin are held stable.
  - After CHECK_WAIT cycles, welcome_in is sampled once at the last CHECK cycle.
  - welcome_in=1 → GRANTED, grant=1, tries=0, HasAccess=0.
  - welcome_in=0 → fail_evt=1 for one cycle and tries+1.
    - New tries==MAX_TRIES → LOCKED, HasAccess=0, Input_Pin=0.
    - Otherwise → WAIT_PIN, Input_Pin=0, HasAccess stays 1, timeout timer restarts.
- GRANTED:
  - grant=1 for exactly GRANT_CYCLES cycles, then IDLE with grant=0.
  - Card and key inputs are ignored.
- LOCKED:
  - locked=1 for exactly LOCK_CYCLES cycles, then IDLE with locked=0 and tries=0.
  - All card and key inputs are ignored.
- Counting and widths:
  - tries saturates at MAX_TRIES and never wraps.
  - tries persists across a timeout; it clears only on success, on lockout exit, or on reset.
  - Timer width is $clog2 of the largest of TIMEOUT_CYCLES, GRANT_CYCLES, LOCK_CYCLES, CHECK_WAIT.
- Strobes arriving in states where they are ignored are dropped, not queued.

Test Plan:
All scenarios use TIMEOUT_CYCLES=8, CHECK_WAIT=2, MAX_TRIES=3, GRANT_CYCLES=4, LOCK_CYCLES=6.
- Reset: hold rst_n=0 for 2 clks with card_valid=1, card_ok=1 → all outputs 0 and state IDLE; HasAccess still 0 on the first clk after release.
- Happy path: card_ok strobe, then key 4'hF strobe, welcome_in=1 during CHECK → Input_Pin=4'hF, HasAccess=1 through CHECK; grant high exactly 4 cycles; tries=0; back to IDLE.
- Wrong PIN ×3: card_ok, then keys 4'h1, 4'h2, 4'h3 with welcome_in=0 → three fail_evt pulses, tries 1,2,3; locked=1 for 6 cycles; HasAccess=0; a key strobe during lock has no effect; then locked=0, tries=0.
- Timeout: card_ok, no key for 8 cycles → timeout_evt pulse on the 8th WAIT_PIN cycle, HasAccess=0, Input_Pin=0. Repeat with key_valid on that exact 8th cycle → CHECK entered, no timeout_evt.
- Retry then success: one wrong PIN (tries=1), then key 4'hF with welcome_in=1 → grant asserted, tries returns to 0.
- Reset mid-GRANTED and mid-LOCKED: assert rst_n=0 on the 2nd grant cycle, and separately on the 3rd lock cycle → next cycle grant=0, locked=0, tries=0, state IDLE.
